present80_enc_ctrl: RTL and testbench
=====================================

// Module: present80_enc_ctrl
// PURPOSE
//   Iterative PRESENT-80 encryption engine that sequences the team's 4-bit sbox.
//   The 64-bit S-layer is processed over 16/SBOX_PAR cycles by SBOX_PAR shared
//   sbox instances, plus one dedicated sbox for the key schedule.
//   The FSM sequences addRoundKey, S-layer, pLayer and key update for 31 rounds,
//   then the final key whitening. It sits under the IP-core bus wrapper.
// PARAMETERS
//   SBOX_PAR  16  sbox instances in the state path; legal values 1,2,4,8,16
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   request; sampled only while ready=1
//   plaintext   in   64  block, captured on the accepting edge
//   key         in   80  key, captured on the accepting edge
//   ready       out  1   high in IDLE; start is accepted
//   busy        out  1   high from the accepting edge until the FINAL step
//   done        out  1   one-cycle pulse; ciphertext is valid
//   ciphertext  out  64  result register; held until the next completion
// BEHAVIOUR
//   Reset: FSM=IDLE, ready=1, busy=0, done=0, ciphertext=0.
//     State, key and round registers are cleared to 0.
//   Nibble n = state[4n+3:4n]. Round counter rc is 5 bits, values 1..31.
//   FSM states: IDLE, ADD, SUB, PERM, FINAL.
//   IDLE
//     On start: state<=plaintext, kreg<=key, rc<=1, grp<=0; go to ADD.
//   ADD
//     state<=state^kreg[79:16]; go to SUB.
//   SUB
//     Nibbles grp*SBOX_PAR..grp*SBOX_PAR+SBOX_PAR-1 <= S(nibble).
//     Other nibbles hold. grp increments.
//     At the last group (grp=16/SBOX_PAR-1), grp<=0 and go to PERM.
//   PERM
//     pLayer: bit i moves to (16*i) mod 63 for i<63; bit 63 stays.
//     Key update in the same cycle:
//       k={kreg[18:0],kreg[79:19]}; k[79:76]=S(k[79:76]);
//       k[19:15]^=rc; kreg<=k.
//     If rc==31, go to FINAL. Otherwise rc<=rc+1 and go to ADD.
//   FINAL
//     ciphertext<=state^kreg[79:16]; done<=1 for exactly one cycle;
//     busy<=0, ready<=1; FSM returns to IDLE.
//   Latency
//     The FSM takes 31*(2+16/SBOX_PAR)+1 edges after the accepting edge.
//     done is high in the cycle after the last of these edges.
//     SBOX_PAR=16: 94 edges. SBOX_PAR=1: 559 edges.
//   Boundary conditions
//     start while busy is ignored. Inputs may change freely after acceptance.
//     done and ready are high in the same cycle, and start is legal then.
//       It is accepted and ciphertext keeps the old value until the next FINAL.
//     start held high continuously runs back-to-back encryptions.
//       Each new block is captured on the edge after done.
//     rst asserted mid-operation aborts immediately to the reset values.
//       No done pulse is produced.
//     rc never wraps: PERM with rc=31 always exits to FINAL.
// TESTING
//   1. pt=0, key=0, SBOX_PAR=16
//      -> ciphertext=5579C1387B228445; done at 94 edges after accept.
//   2. pt=0, key=FFFFFFFFFFFFFFFFFFFF
//      -> ciphertext=E72C46C0F5945049.
//   3. pt=FFFFFFFFFFFFFFFF, key=0
//      -> ciphertext=A112FFC72F68417B.
//   4. pt=all-ones, key=all-ones, repeated for SBOX_PAR=1,2,4,8
//      -> ciphertext=3333DCD3213210D2.
//      done at 31*(2+16/SBOX_PAR)+1 edges each time.
//   5. Pulse start again at edge 10 while busy with new pt/key
//      -> ignored; vector 1 result is unchanged.
//      Then hold start high -> two back-to-back results, each with a single done pulse.
//   6. Assert rst at edge 40 of an encryption
//      -> ready=1, busy=0, done=0, ciphertext=0 immediately.
//      A new start then completes correctly.

Source files
------------

// File: rtl/present80_enc_ctrl.sv
// Iterative PRESENT-80 encryption engine: one round per ADD/SUB/PERM pass,
// with the S-layer spread over 16/SBOX_PAR cycles and a dedicated key-schedule sbox.
module present80_enc_ctrl #(
   parameter int SBOX_PAR = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [63:0] plaintext_i,
   input  logic [79:0] key_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] ciphertext_o
);
   localparam int NGRP = 16 / SBOX_PAR;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

   typedef enum logic [2:0] {IDLE, ADD, SUB, PERM, FINAL} fsm_t;

   fsm_t        fsm_q, fsm_d;
   logic [63:0] state_q, state_d;
   logic [79:0] kreg_q, kreg_d;
   logic [4:0]  rc_q, rc_d;
   logic [GW-1:0] grp_q, grp_d;
   logic        done_q, done_d;
   logic [63:0] ct_q, ct_d;

   logic [63:0] sub_state;
   logic [63:0] perm_state;
   logic [79:0] key_rot;
   logic [79:0] key_next;
   logic [5:0]  grp_base;
   logic [3:0]  sb_in  [SBOX_PAR];
   logic [3:0]  sb_out [SBOX_PAR];

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // Bit offset of the first nibble handled in the current S-layer group.
   assign grp_base = 6'(int'(grp_q) * SBOX_PAR * 4);

   genvar gi;
   generate
      for (gi = 0; gi < SBOX_PAR; gi++) begin : g_sbox
         assign sb_in[gi]  = state_q[grp_base + 6'(gi * 4) +: 4];
         assign sb_out[gi] = sbox(sb_in[gi]);
      end
      for (gi = 0; gi < 64; gi++) begin : g_perm
         localparam int DST = (gi == 63) ? 63 : (16 * gi) % 63;
         assign perm_state[DST] = state_q[gi];
      end
   endgenerate

   always_comb begin
      sub_state = state_q;
      for (int j = 0; j < SBOX_PAR; j++) begin
         sub_state[grp_base + 6'(j * 4) +: 4] = sb_out[j];
      end
   end

   // Key schedule: rotate left by 61, sbox the top nibble, fold in the round counter.
   assign key_rot  = {kreg_q[18:0], kreg_q[79:19]};
   assign key_next = {sbox(key_rot[79:76]), key_rot[75:20], key_rot[19:15] ^ rc_q, key_rot[14:0]};

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      kreg_d  = kreg_q;
      rc_d    = rc_q;
      grp_d   = grp_q;
      done_d  = 1'b0;
      ct_d    = ct_q;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               state_d = plaintext_i;
               kreg_d  = key_i;
               rc_d    = 5'd1;
               grp_d   = '0;
               fsm_d   = ADD;
            end
         end
         ADD: begin
            state_d = state_q ^ kreg_q[79:16];
            fsm_d   = SUB;
         end
         SUB: begin
            state_d = sub_state;
            if (grp_q == GRP_LAST) begin
               grp_d = '0;
               fsm_d = PERM;
            end else begin
               grp_d = grp_q + GW'(1);
            end
         end
         PERM: begin
            state_d = perm_state;
            kreg_d  = key_next;
            if (rc_q == 5'd31) begin
               fsm_d = FINAL;
            end else begin
               rc_d  = rc_q + 5'd1;
               fsm_d = ADD;
            end
         end
         FINAL: begin
            ct_d   = state_q ^ kreg_q[79:16];
            done_d = 1'b1;
            fsm_d  = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         kreg_q  <= '0;
         rc_q    <= '0;
         grp_q   <= '0;
         done_q  <= 1'b0;
         ct_q    <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         kreg_q  <= kreg_d;
         rc_q    <= rc_d;
         grp_q   <= grp_d;
         done_q  <= done_d;
         ct_q    <= ct_d;
      end
   end

   assign ready_o      = (fsm_q == IDLE);
   assign busy_o       = (fsm_q != IDLE);
   assign done_o       = done_q;
   assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_present80_enc_ctrl.sv
// Directed bench for present80_enc_ctrl: known-answer vectors, latency for every
// SBOX_PAR, start-while-busy, back-to-back runs and mid-operation reset.
module tb_present80_enc_ctrl;
   localparam logic [63:0] PT0  = 64'h0;
   localparam logic [63:0] PT1  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] K0   = 80'h0;
   localparam logic [79:0] K1   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] CT00 = 64'h5579_C138_7B22_8445;
   localparam logic [63:0] CT01 = 64'hE72C_46C0_F594_5049;
   localparam logic [63:0] CT10 = 64'hA112_FFC7_2F68_417B;
   localparam logic [63:0] CT11 = 64'h3333_DCD3_2132_10D2;
   localparam int LAT16 = 94;

   logic        clk;
   logic        rst;
   logic        start;
   logic        start_p;
   logic [63:0] pt;
   logic [79:0] key;
   logic        ready, busy, done;
   logic [63:0] ct;
   logic        ready_x [4];
   logic        busy_x  [4];
   logic        done_x  [4];
   logic [63:0] ct_x    [4];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   present80_enc_ctrl #(.SBOX_PAR(16)) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .plaintext_i(pt), .key_i(key),
      .ready_o(ready), .busy_o(busy), .done_o(done), .ciphertext_o(ct)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_par
         present80_enc_ctrl #(.SBOX_PAR(1 << gi)) u_dut (
            .clk(clk), .rst(rst), .start_i(start_p), .plaintext_i(pt), .key_i(key),
            .ready_o(ready_x[gi]), .busy_o(busy_x[gi]), .done_o(done_x[gi]),
            .ciphertext_o(ct_x[gi])
         );
      end
   endgenerate

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (ct !== 64'h0) begin n_fail++; $display("FAIL reset_ct got %h want 0", ct); end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if (ready_x[j] !== 1'b1 || ct_x[j] !== 64'h0) begin
            n_fail++; $display("FAIL reset_par%0d ready=%b ct=%h want 1/0", 1 << j, ready_x[j], ct_x[j]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset: checked idle outputs");
   endtask

   task automatic run_main(input logic [63:0] p, input logic [79:0] k,
                           input logic [63:0] exp_ct, input string name);
      int lat = 0;
      start = 1'b1; pt = p; key = k;
      tick();
      start = 1'b0;
      n_tests++; if (busy !== 1'b1 || ready !== 1'b0) begin
         n_fail++; $display("FAIL %s_busy busy=%b ready=%b want 1/0", name, busy, ready);
      end
      for (int n = 1; n <= 700; n++) begin
         tick();
         if (done === 1'b1) begin lat = n; break; end
      end
      n_tests++; if (lat != LAT16) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT16); end
      n_tests++; if (ct !== exp_ct) begin n_fail++; $display("FAIL %s_ct got %h want %h", name, ct, exp_ct); end
      n_tests++; if (ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s_ready_at_done ready=%b busy=%b want 1/0", name, ready, busy);
      end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
      $display("[TB] %s: pt=%h key=%h ct=%h latency=%0d", name, p, k, ct, lat);
   endtask

   task automatic test_vectors();
      run_main(PT0, K0, CT00, "vec_pt0_k0");
      run_main(PT0, K1, CT01, "vec_pt0_k1");
      run_main(PT1, K0, CT10, "vec_pt1_k0");
   endtask

   task automatic test_sbox_par();
      int exp_lat [4] = '{559, 311, 187, 125};
      int lat [4] = '{0, 0, 0, 0};
      logic [63:0] got [4];
      run_main(PT1, K1, CT11, "par16");
      start_p = 1'b1; pt = PT1; key = K1;
      tick();
      start_p = 1'b0; pt = PT0; key = K0;
      for (int n = 1; n <= 600; n++) begin
         tick();
         for (int j = 0; j < 4; j++) begin
            if (done_x[j] === 1'b1 && lat[j] == 0) begin lat[j] = n; got[j] = ct_x[j]; end
         end
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++; if (lat[j] != exp_lat[j]) begin
            n_fail++; $display("FAIL par%0d_latency got %0d want %0d", 1 << j, lat[j], exp_lat[j]);
         end
         n_tests++; if (got[j] !== CT11) begin
            n_fail++; $display("FAIL par%0d_ct got %h want %h", 1 << j, got[j], CT11);
         end
         $display("[TB] par%0d: ct=%h latency=%0d", 1 << j, got[j], lat[j]);
      end
   endtask

   task automatic test_ignore_start();
      int lat = 0;
      start = 1'b1; pt = PT0; key = K0;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 700; n++) begin
         tick();
         if (n == 10) begin start = 1'b1; pt = PT1; key = K1; end
         if (n == 11) start = 1'b0;
         if (n == 20) begin
            n_tests++; if (ct !== CT11) begin n_fail++; $display("FAIL ignore_ct_held got %h want %h", ct, CT11); end
         end
         if (done === 1'b1) begin lat = n; break; end
      end
      n_tests++; if (lat != LAT16) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT16); end
      n_tests++; if (ct !== CT00) begin n_fail++; $display("FAIL ignore_ct got %h want %h", ct, CT00); end
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart busy=%b want 0", busy); end
      $display("[TB] ignore_start: ct=%h latency=%0d", ct, lat);
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int t1 = 0;
      int t2 = 0;
      logic [63:0] c1 = '0;
      logic [63:0] c2 = '0;
      start = 1'b1; pt = PT0; key = K1;
      tick();
      pt = PT1; key = K0;
      for (int n = 1; n <= 260; n++) begin
         tick();
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin t1 = n; c1 = ct; end
            else if (ndone == 2) begin t2 = n; c2 = ct; end
         end
         if (t1 != 0 && n == t1 + 1) begin
            start = 1'b0;
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept busy=%b want 1", busy); end
            n_tests++; if (ct !== CT01) begin n_fail++; $display("FAIL b2b_ct_held got %h want %h", ct, CT01); end
         end
      end
      start = 1'b0;
      n_tests++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
      n_tests++; if (t1 != 94 || t2 != 189) begin n_fail++; $display("FAIL b2b_timing got %0d/%0d want 94/189", t1, t2); end
      n_tests++; if (c1 !== CT01) begin n_fail++; $display("FAIL b2b_ct1 got %h want %h", c1, CT01); end
      n_tests++; if (c2 !== CT10) begin n_fail++; $display("FAIL b2b_ct2 got %h want %h", c2, CT10); end
      $display("[TB] back_to_back: ct1=%h@%0d ct2=%h@%0d dones=%0d", c1, t1, c2, t2, ndone);
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      start = 1'b1; pt = PT0; key = K1;
      tick();
      start = 1'b0;
      repeat (39) tick();
      rst = 1'b1;
      #1;
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", ready); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
      n_tests++; if (ct !== 64'h0) begin n_fail++; $display("FAIL abort_ct got %h want 0", ct); end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 120; n++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone); end
      $display("[TB] reset_abort: outputs cleared, dones after abort=%0d", ndone);
      run_main(PT0, K0, CT00, "abort_recover");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_p = 1'b0; pt = '0; key = '0;
      test_reset();
      test_vectors();
      test_sbox_par();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
